// File: rtl/sync_down_counter.sv
// Programmable synchronous down-counter with one-shot/auto-reload modes.
// Ports: clk/rst (sync, active-high); start_i, counter_i, reload_i,
//   pause_i, stop_i in; busy_o (in RUN), counter_o, end_o (registered) out.
module sync_down_counter #(
  parameter int counter_bits = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [counter_bits-1:0] counter_i,
  input  logic                    reload_i,
  input  logic                    pause_i,
  input  logic                    stop_i,
  output logic                    busy_o,
  output logic [counter_bits-1:0] counter_o,
  output logic                    end_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [counter_bits-1:0] ONE  = counter_bits'(1);
  localparam logic [counter_bits-1:0] ZERO = '0;

  state_t                  r_state;
  logic [counter_bits-1:0] r_cnt;
  logic                    r_end;
  logic [counter_bits-1:0] r_load;
  logic                    r_reload;

  state_t                  w_state;
  logic [counter_bits-1:0] w_cnt;
  logic                    w_end;
  logic [counter_bits-1:0] w_load;
  logic                    w_reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= ZERO;
      r_end    <= 1'b0;
      r_load   <= ZERO;
      r_reload <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_end    <= w_end;
      r_load   <= w_load;
      r_reload <= w_reload;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_end    = 1'b0;
    w_load   = r_load;
    w_reload = r_reload;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (counter_i != ZERO) begin
            w_load   = counter_i;
            w_reload = reload_i;
            w_cnt    = counter_i;
            w_state  = S_RUN;
          end else begin
            // Zero-length run: immediate end pulse, never armed.
            w_end = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop_i) begin
          w_state = S_IDLE;
          w_cnt   = ZERO;
        end else if (pause_i) begin
          w_cnt = r_cnt;
        end else if (r_cnt > ONE) begin
          w_cnt = r_cnt - ONE;
        end else if (r_cnt == ONE) begin
          w_cnt = ZERO;
          w_end = 1'b1;
          if (!r_reload) w_state = S_IDLE;
        end else begin
          // Zero cycle of reload mode: reload without a second pulse.
          w_cnt = r_load;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign busy_o    = (r_state == S_RUN);
  assign counter_o = r_cnt;
  assign end_o     = r_end;

endmodule
